// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
//   ADDR_W / DATA_W  : default word address and data widths
//   IO_ADDR          : address whose write also strobes the io port
//   REQ_*            : fixed requester IDs
//   tag_t            : read-return tag {valid, id}
package dmem_pkg;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DATA_W  = 64;
   localparam logic [ADDR_W-1:0] IO_ADDR = 8'hFF;

   localparam int unsigned REQ_CPU = 0;
   localparam int unsigned REQ_DBG = 1;
   localparam int unsigned REQ_DMA = 2;

   // Sized for the largest supported requester count so one tag type serves all builds.
   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned ID_W    = $clog2(MAX_REQ);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Round-robin arbiter with burst lock.
//   clk, rst (sync, active-low)
//   arb_en : 0 blocks all new grants
//   req    : request per requester
//   lock   : keep the grant after this beat
//   gnt    : combinational one-hot grant
// Pointer and lock owner are held one-hot so the priority search needs no indexing.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arb_en,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] lock,
   output logic [NUM_REQ-1:0] gnt
);

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   logic [NUM_REQ-1:0] ptr_oh;
   logic [NUM_REQ-1:0] owner_oh;
   logic [NUM_REQ-1:0] req_hi;
   logic [NUM_REQ-1:0] cand;
   logic               xfer;
   logic               keep;

   // Search from the pointer upward; fall back to the full vector to wrap around.
   always_comb begin
      req_hi = req & ~(ptr_oh - ONE);
      cand   = (|req_hi) ? req_hi : req;
      gnt    = '0;
      if (rst && arb_en) begin
         if (|owner_oh) gnt = req & owner_oh;
         else           gnt = cand & (~cand + ONE);
      end
   end

   assign xfer = |gnt;
   assign keep = |(gnt & lock);

   // Locked beats park ownership and leave the pointer where it is.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_oh   <= ONE;
         owner_oh <= '0;
      end else if (xfer) begin
         if (keep) begin
            owner_oh <= gnt;
         end else begin
            owner_oh <= '0;
            ptr_oh   <= {gnt[NUM_REQ-2:0], gnt[NUM_REQ-1]};
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous RAM among NUM_REQ requesters.
//   clk, rst (sync, active-low), arb_en
//   req/we/lock/addr/wdata : packed per-requester command inputs
//   gnt                    : combinational one-hot ready
//   rvalid/rdata           : read return, 3 edges after acceptance
//   mem_*                  : registered RAM command, mem_rdata one cycle after a read
//   io_write/io_data       : strobe on writes to IO_ADDR
module dmem_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = dmem_pkg::ADDR_W,
   parameter int unsigned DATA_W  = dmem_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(dmem_pkg::IO_ADDR)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arb_en,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         we,
   input  logic [NUM_REQ-1:0]         lock,
   input  logic [NUM_REQ*ADDR_W-1:0]  addr,
   input  logic [NUM_REQ*DATA_W-1:0]  wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic                       mem_en,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       io_write,
   output logic [DATA_W-1:0]          io_data
);

   import dmem_pkg::*;

   logic              xfer;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [ID_W-1:0]   sel_id;
   logic              io_hit;
   tag_t              tag1;
   tag_t              tag2;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk    (clk),
      .rst    (rst),
      .arb_en (arb_en),
      .req    (req),
      .lock   (lock),
      .gnt    (gnt)
   );

   // One-hot AND-OR mux of the granted requester's command.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_we    = we[i];
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
            sel_id    = ID_W'(i);
         end
      end
   end

   assign xfer   = |gnt;
   assign io_hit = xfer & sel_we & (sel_addr == IO_ADDR);

   // Command registers, two-stage read tag pipeline, read return and IO strobe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         tag1      <= '0;
         tag2      <= '0;
         rvalid    <= '0;
         rdata     <= '0;
         io_write  <= 1'b0;
         io_data   <= '0;
      end else begin
         mem_en <= xfer;
         mem_we <= xfer & sel_we;
         if (xfer) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end
         tag1.valid <= xfer & ~sel_we;
         tag1.id    <= sel_id;
         // tag2 lines up with the RAM sampling the command; mem_rdata is ready one edge later.
         tag2   <= tag1;
         rvalid <= tag2.valid ? (NUM_REQ'(1) << tag2.id) : '0;
         if (tag2.valid) rdata <= mem_rdata;
         io_write <= io_hit;
         io_data  <= io_hit ? sel_wdata : '0;
      end
   end

endmodule
